// File: rtl/io_bridge_pkg.sv
// rtl/io_bridge_pkg.sv - shared widths, default FIFO depths and byte helpers for io_fifo_bridge
package io_bridge_pkg;

  localparam int BYTE_W            = 8;
  localparam int WORD_W            = 32;
  localparam int TX_DEPTH_LOG2_DEF = 4;
  localparam int RX_DEPTH_LOG2_DEF = 4;

  function automatic logic [WORD_W-1:0] zext_byte(input logic [BYTE_W-1:0] b);
    return {{(WORD_W-BYTE_W){1'b0}}, b};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with MSB-extended binary pointers
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [WIDTH-1:0]    mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign dout  = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Caller guarantees push only when there is room (or a same-cycle pop) and pop only when non-empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/io_fifo_bridge.sv
// rtl/io_fifo_bridge.sv - core I/O port to UART byte FIFOs; IO_BRIDGE_RX_FWD_EN enables RX bypass
module io_fifo_bridge
  import io_bridge_pkg::*;
#(
  parameter int TX_DEPTH_LOG2 = TX_DEPTH_LOG2_DEF,
  parameter int RX_DEPTH_LOG2 = RX_DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_issued,
  input  logic [WORD_W-1:0] out_data,
  output logic              out_stall,
  input  logic              in_issued,
  output logic [WORD_W-1:0] in_data,
  output logic              in_stall,
  input  logic [WORD_W-1:0] result_bytes,
  output logic [BYTE_W-1:0] tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [BYTE_W-1:0] rx_byte,
  input  logic              rx_valid,
  output logic [WORD_W-1:0] tx_count,
  output logic              done,
  output logic              rx_overrun
);

  logic                   tx_full, tx_empty, tx_push, tx_pop;
  logic                   rx_full, rx_empty, rx_push, rx_pop;
  logic                   rx_fwd;
  logic [BYTE_W-1:0]      rx_head;
  logic [TX_DEPTH_LOG2:0] tx_level;
  logic [RX_DEPTH_LOG2:0] rx_level;
  logic                   unused_bits;

  assign unused_bits = ^{out_data[WORD_W-1:BYTE_W], tx_level, rx_level};

  // TX: a full FIFO refuses the push even if the UART drains an entry this cycle.
  assign out_stall = out_issued && tx_full;
  assign tx_push   = out_issued && !tx_full;
  assign tx_valid  = !tx_empty;
  assign tx_pop    = tx_valid && tx_ready;

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (out_data[BYTE_W-1:0]),
    .dout  (tx_byte),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_level)
  );

`ifdef IO_BRIDGE_RX_FWD_EN
  assign rx_fwd = rx_empty && rx_valid && in_issued;
`else
  assign rx_fwd = 1'b0;
`endif

  // RX: a full FIFO still takes the strobe when the core reads in the same cycle.
  assign rx_pop   = in_issued && !rx_empty;
  assign rx_push  = rx_valid && !rx_fwd && (!rx_full || rx_pop);
  assign in_stall = in_issued && rx_empty && !rx_fwd;

  always_comb begin
    in_data = '0;
    if (rx_fwd)         in_data = zext_byte(rx_byte);
    else if (!rx_empty) in_data = zext_byte(rx_head);
  end

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_byte),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_count   <= '0;
      done       <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (tx_pop) tx_count <= tx_count + 32'd1;
      if (rx_valid && rx_full && !rx_pop) rx_overrun <= 1'b1;
      if ((result_bytes != '0) && (tx_count >= result_bytes) && tx_empty) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_fifo_bridge.sv
// tb/tb_io_fifo_bridge.sv - directed vector and sequence bench for io_fifo_bridge
module tb_io_fifo_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        out_issued = 1'b0;
  logic [31:0] out_data = '0;
  logic        out_stall;
  logic        in_issued = 1'b0;
  logic [31:0] in_data;
  logic        in_stall;
  logic [31:0] result_bytes = '0;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic [31:0] tx_count;
  logic        done;
  logic        rx_overrun;

  int n_cmp = 0;
  int n_bad = 0;

  io_fifo_bridge dut (
    .clk(clk), .rst(rst),
    .out_issued(out_issued), .out_data(out_data), .out_stall(out_stall),
    .in_issued(in_issued), .in_data(in_data), .in_stall(in_stall),
    .result_bytes(result_bytes),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_count(tx_count), .done(done), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        oi;
    logic [7:0]  od;
    logic        tr;
    logic        rv;
    logic [7:0]  rb;
    logic        ii;
    logic        e_out_stall;
    logic        e_tx_valid;
    logic [7:0]  e_tx_byte;
    logic        e_in_stall;
    logic [31:0] e_in_data;
    logic [31:0] e_tx_count;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    out_issued = 1'b0; out_data = '0; tx_ready = 1'b0;
    in_issued = 1'b0; rx_valid = 1'b0; rx_byte = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Compact vector table: inputs driven at negedge, outputs checked before the next posedge.
    vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0, 32'd0};
`ifdef IO_BRIDGE_RX_FWD_EN
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'hA5, 32'd0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0, 32'd0};
`else
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h0, 32'd0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'hA5, 32'd0};
`endif
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'd0};
    vecs[4] = '{1'b1, 8'h23, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'd0};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h23, 1'b0, 32'h0, 32'd0};
    vecs[6] = '{1'b1, 8'h44, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h23, 1'b0, 32'h0, 32'd0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 32'h0, 32'd1};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 32'h0, 32'd1};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'd2};

    // Reset state
    #12;
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_tx_count", tx_count, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_rx_overrun", {31'b0, rx_overrun}, 32'd0);
    chk("rst_in_data", in_data, 32'd0);
    chk("rst_out_stall", {31'b0, out_stall}, 32'd0);
    chk("rst_in_stall", {31'b0, in_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      out_issued = vecs[i].oi; out_data = {24'hABCDEF, vecs[i].od};
      tx_ready = vecs[i].tr; rx_valid = vecs[i].rv; rx_byte = vecs[i].rb;
      in_issued = vecs[i].ii;
      #1;
      chk($sformatf("v%0d_out_stall", i), {31'b0, out_stall}, {31'b0, vecs[i].e_out_stall});
      chk($sformatf("v%0d_tx_valid", i), {31'b0, tx_valid}, {31'b0, vecs[i].e_tx_valid});
      if (vecs[i].e_tx_valid) chk($sformatf("v%0d_tx_byte", i), {24'b0, tx_byte}, {24'b0, vecs[i].e_tx_byte});
      chk($sformatf("v%0d_in_stall", i), {31'b0, in_stall}, {31'b0, vecs[i].e_in_stall});
      chk($sformatf("v%0d_in_data", i), in_data, vecs[i].e_in_data);
      chk($sformatf("v%0d_tx_count", i), tx_count, vecs[i].e_tx_count);
    end

    // Reset mid-operation with 3 bytes queued
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_issued = 1'b1; out_data = 32'h60 + i;
    end
    @(negedge clk);
    out_issued = 1'b0;
    #1;
    chk("mid_pre_tx_valid", {31'b0, tx_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("mid_rst_tx_count", tx_count, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tx_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("mid_post_tx_valid_%0d", c), {31'b0, tx_valid}, 32'd0);
    end
    chk("mid_post_tx_count", tx_count, 32'd0);

    // TX fill: 17th write stalls
    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      out_issued = 1'b1; out_data = i;
      #1;
      chk($sformatf("fill_out_stall_%0d", i), {31'b0, out_stall}, (i == 16) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    out_issued = 1'b0;
    tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_valid_%0d", i), {31'b0, tx_valid}, 32'd1);
      chk($sformatf("drain_byte_%0d", i), {24'b0, tx_byte}, i);
      @(negedge clk);
      #1;
    end
    chk("drain_empty", {31'b0, tx_valid}, 32'd0);
    chk("drain_tx_count", tx_count, 32'd16);
    @(negedge clk);
    tx_ready = 1'b0;
    out_issued = 1'b1; out_data = 32'h10;
    @(negedge clk);
    out_issued = 1'b0; tx_ready = 1'b1;
    #1;
    chk("fill_retry_byte", {24'b0, tx_byte}, 32'h10);
    @(negedge clk);
    #1;
    chk("fill_tx_count", tx_count, 32'd17);

    // RX overrun: 17 strobes, no reads
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      rx_valid = 1'b1; rx_byte = i;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
    chk("ovr_flag", {31'b0, rx_overrun}, 32'd1);
    in_issued = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("ovr_stall_%0d", i), {31'b0, in_stall}, 32'd0);
      chk($sformatf("ovr_data_%0d", i), in_data, i);
      @(negedge clk);
      #1;
    end
    chk("ovr_empty_stall", {31'b0, in_stall}, 32'd1);

    // No overrun when the 17th strobe coincides with a read
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      rx_valid = 1'b1; rx_byte = i;
      in_issued = (i == 17);
      #1;
      if (i == 17) chk("noovr_read_data", in_data, 32'd1);
    end
    @(negedge clk);
    rx_valid = 1'b0; in_issued = 1'b1;
    #1;
    chk("noovr_flag", {31'b0, rx_overrun}, 32'd0);
    for (int i = 2; i <= 17; i++) begin
      chk($sformatf("noovr_data_%0d", i), in_data, i);
      @(negedge clk);
      #1;
    end
    chk("noovr_empty_stall", {31'b0, in_stall}, 32'd1);

    // Done after 4 bytes
    do_reset();
    result_bytes = 32'd4;
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      out_issued = 1'b1; out_data = 32'h70 + k;
    end
    @(negedge clk);
    out_issued = 1'b0;
    @(negedge clk);
    #1;
    chk("done_tx_count", tx_count, 32'd4);
    chk("done_not_yet", {31'b0, done}, 32'd0);
    chk("done_tx_empty", {31'b0, tx_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("done_set", {31'b0, done}, 32'd1);
    result_bytes = 32'd100;
    repeat (2) @(negedge clk);
    #1;
    chk("done_sticky", {31'b0, done}, 32'd1);

    // result_bytes == 0 never completes
    do_reset();
    result_bytes = 32'd0;
    tx_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      out_issued = 1'b1; out_data = k;
    end
    @(negedge clk);
    out_issued = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("zero_tx_count", tx_count, 32'd2);
    chk("zero_done", {31'b0, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_fifo_bridge.md
Name: io_fifo_bridge

Overview:
- Sits directly downstream of the pipeline core's I/O port.
- Consumes out_issued/out_data/in_issued/result_bytes from the core and returns out_stall/in_stall/in_data.
- Decouples the core from the byte-serial UART side with a TX FIFO and an RX FIFO.
- Tracks transmitted bytes against the core-reported result size and raises a completion flag.

Parameters:
- TX_DEPTH_LOG2, 4, log2 of TX FIFO depth (16 entries).
- RX_DEPTH_LOG2, 4, log2 of RX FIFO depth (16 entries).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- out_issued  in  1  core requests a byte write this cycle.
- out_data  in  32  byte to send is in [7:0]; [31:8] ignored.
- out_stall  out  1  core must hold out_issued/out_data.
- in_issued  in  1  core requests a byte read; held while in_stall is high.
- in_data  out  32  zero-extended RX head byte; valid when in_issued && !in_stall.
- in_stall  out  1  core must hold in_issued.
- result_bytes  in  32  expected total output bytes; sampled continuously.
- tx_byte  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  UART transmitter accepts tx_byte.
- rx_byte  in  8  byte from UART receiver.
- rx_valid  in  1  one-cycle strobe for rx_byte; no backpressure.
- tx_count  out  32  bytes accepted by the UART side since reset.
- done  out  1  all expected output bytes have left the block.
- rx_overrun  out  1  sticky: an RX byte was dropped.

Behaviour:
Reset:
- All FIFO pointers and counts are cleared.
- tx_count=0, done=0, rx_overrun=0, tx_valid=0, in_data=0, out_stall=0, in_stall=0.
- Reset takes effect immediately, including mid-transfer; FIFO contents are discarded.

TX path:
- out_stall = out_issued && tx_full (combinational).
- Push on out_issued && !tx_full.
- No pass-through when full: a push is refused even if tx_ready pops in the same cycle.
- tx_valid = !tx_empty; tx_byte = FIFO head.
- Pop on tx_valid && tx_ready.
- Push and pop in the same cycle are both performed; count is unchanged.
- tx_count increments by 1 per pop and wraps at 2^32.

RX path:
- Push on rx_valid.
- If rx_full: the byte is accepted when a pop occurs in the same cycle; otherwise it is dropped and rx_overrun is set.
- in_stall = in_issued && rx_empty (combinational).
- in_data = {24'b0, head} when the FIFO is non-empty, otherwise 0.
- Pop on in_issued && !rx_empty.
- Minimum latency from rx_valid to an unstalled read is 1 cycle.

Pointers:
- Binary pointers are DEPTH_LOG2+1 bits wide; the MSB distinguishes full from empty, and pointers wrap naturally.

Done logic:
- Registered: done <= (result_bytes != 0) && (tx_count >= result_bytes) && tx_empty.
- Once set, done stays set until reset.

Optional Feature:
- Macro: IO_BRIDGE_RX_FWD_EN.
- Defined: when rx_empty && rx_valid && in_issued in the same cycle, rx_byte is forwarded combinationally. in_data = {24'b0, rx_byte}, in_stall=0, and the byte is not written to the FIFO. Zero-cycle latency.
- Undefined: the byte is always written first, and in_stall stays high that cycle.

Decomposition:
- Package io_bridge_pkg holds:
  - BYTE_W=8 and WORD_W=32.
  - The default depth constants.
  - The helper function zext_byte.
- One sub-module, sync_fifo (params WIDTH, DEPTH_LOG2; ports push/pop/din/dout/full/empty/count), instantiated once for TX and once for RX.
- Overrun, forwarding and done logic live in the top level.

Test Plan:
- Reset mid-operation: fill TX with 3 bytes, pulse rst low -> tx_valid=0, tx_count=0, and after release tx_empty with no stale byte emitted.
- TX fill: tx_ready=0, issue 17 writes 0x00..0x10 -> out_stall=1 exactly on the 17th; then tx_ready=1 -> bytes 0x00..0x10 emerge in order and tx_count=17.
- RX stall: in_issued=1 with RX empty -> in_stall=1; rx_valid with 0xA5 -> next cycle in_stall=0, in_data=0x000000A5, popped. With IO_BRIDGE_RX_FWD_EN defined, in_stall=0 in the same cycle instead.
- RX overrun: 17 rx_valid strobes 0x01..0x11 with no reads -> rx_overrun=1 and reads return 0x01..0x10. Repeat with in_issued high on the 17th strobe -> no overrun.
- Done: result_bytes=4, send 4 bytes with tx_ready=1 -> done=1 the cycle after the 4th pop and the FIFO empty; with result_bytes=0, done stays 0.
- Simultaneous push/pop: TX holding 1 entry, out_issued and tx_ready together -> count stays 1 and order is preserved.
